// File: rtl/offnariscv_ace_mem_responder_if.sv
// rtl/offnariscv_ace_mem_responder_if.sv - ACE read/write channel bundle between initiator and memory responder
interface offnariscv_ace_mem_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int ACE_XID_WIDTH     = 4;
    localparam int ACE_AXLEN_WIDTH   = 8;
    localparam int ACE_AXSIZE_WIDTH  = 3;
    localparam int ACE_AXBURST_WIDTH = 2;
    localparam int ACE_ARSNOOP_WIDTH = 4;
    localparam int ACE_AWSNOOP_WIDTH = 3;
    localparam int ACE_DOMAIN_WIDTH  = 2;
    localparam int ACE_RRESP_WIDTH   = 4;
    localparam int ACE_BRESP_WIDTH   = 2;

    logic [ACE_XID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]        araddr;
    logic [ACE_AXLEN_WIDTH-1:0]   arlen;
    logic [ACE_AXSIZE_WIDTH-1:0]  arsize;
    logic [ACE_AXBURST_WIDTH-1:0] arburst;
    logic [ACE_ARSNOOP_WIDTH-1:0] arsnoop;
    logic [ACE_DOMAIN_WIDTH-1:0]  ardomain;
    logic                         arvalid;
    logic                         arready;

    logic [ACE_XID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]        rdata;
    logic [ACE_RRESP_WIDTH-1:0]   rresp;
    logic                         rlast;
    logic                         rvalid;
    logic                         rready;

    logic [ACE_XID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]        awaddr;
    logic [ACE_AXLEN_WIDTH-1:0]   awlen;
    logic [ACE_AXSIZE_WIDTH-1:0]  awsize;
    logic [ACE_AXBURST_WIDTH-1:0] awburst;
    logic [ACE_AWSNOOP_WIDTH-1:0] awsnoop;
    logic [ACE_DOMAIN_WIDTH-1:0]  awdomain;
    logic                         awvalid;
    logic                         awready;

    logic [DATA_WIDTH-1:0]        wdata;
    logic [DATA_WIDTH/8-1:0]      wstrb;
    logic                         wlast;
    logic                         wvalid;
    logic                         wready;

    logic [ACE_XID_WIDTH-1:0]     bid;
    logic [ACE_BRESP_WIDTH-1:0]   bresp;
    logic                         bvalid;
    logic                         bready;

    logic                         rack;
    logic                         wack;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arsnoop, ardomain, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awsnoop, awdomain, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output rack, wack
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arsnoop, ardomain, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awsnoop, awdomain, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  rack, wack
    );
endinterface

// File: rtl/offnariscv_ace_mem_responder.sv
// rtl/offnariscv_ace_mem_responder.sv - non-snooping ACE memory slave with independent read and write FSMs
module offnariscv_ace_mem_responder #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_BYTES  = 65536,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000
) (
    input logic                           clk,
    input logic                           rst,
    offnariscv_ace_mem_responder_if.slave bus
);
    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int OFF_BITS  = $clog2(STRB_W);
    localparam int MEM_BITS  = $clog2(MEM_BYTES);
    localparam int MEM_WORDS = MEM_BYTES / STRB_W;
    localparam int IDX_W     = MEM_BITS - OFF_BITS;

    typedef enum logic {R_IDLE, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (off >> MEM_BITS) == '0;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> OFF_BITS);
    endfunction

    // WRAP with a power-of-two beat count keeps the upper address bits and wraps the low ones;
    // any other length (and the reserved encoding) simply increments.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        step = ADDR_WIDTH'(1) << size;
        inc  = a + step;
        mask = (ADDR_WIDTH'(len) << size) | (step - ADDR_WIDTH'(1));
        if (burst == 2'b00) begin
            return a;
        end else if (burst == 2'b10 &&
                     (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
            return (a & ~mask) | (inc & mask);
        end
        return inc;
    endfunction

    // Snoop attributes and acknowledges carry no meaning for a non-sharing endpoint.
    logic unused_inputs;
    assign unused_inputs = ^{bus.arsnoop, bus.ardomain, bus.awsnoop, bus.awdomain, bus.rack, bus.wack};

    // ---------------- read side ----------------
    r_state_t              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [2:0]            r_size_q, r_size_d;
    logic [1:0]            r_burst_q, r_burst_d;
    logic [7:0]            r_cnt_q, r_cnt_d;
    logic [3:0]            rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [3:0]            rresp_q, rresp_d;
    logic                  ld_en;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic                  ar_hs, r_hs, r_last;

    assign bus.arready = (r_state_q == R_IDLE) & ~rst;
    assign bus.rvalid  = (r_state_q == R_BURST);
    assign r_last      = (r_cnt_q == r_len_q);
    assign bus.rlast   = bus.rvalid & r_last;
    assign bus.rid     = rid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign ar_hs       = bus.arvalid & bus.arready;
    assign r_hs        = bus.rvalid & bus.rready;

    // Read next-state; the beat payload is loaded into flops so it stays put under backpressure
    // and a write landing in the same cycle does not disturb it.
    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        ld_en     = 1'b0;
        ld_addr   = r_addr_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_addr_d  = bus.araddr;
                    r_len_d   = bus.arlen;
                    r_size_d  = bus.arsize;
                    r_burst_d = bus.arburst;
                    rid_d     = bus.arid;
                    r_cnt_d   = 8'd0;
                    r_state_d = R_BURST;
                    ld_en     = 1'b1;
                    ld_addr   = bus.araddr;
                end
            end
            R_BURST: begin
                if (r_hs) begin
                    if (r_last) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
                        r_cnt_d  = r_cnt_q + 8'd1;
                        ld_en    = 1'b1;
                        ld_addr  = r_addr_d;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (ld_en) begin
            if (in_range(ld_addr)) begin
                rdata_d = mem[word_idx(ld_addr)];
                rresp_d = 4'b0000;
            end else begin
                rdata_d = '0;
                rresp_d = 4'b0011;
            end
        end
    end

    // Read state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_cnt_q   <= '0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // ---------------- write side ----------------
    w_state_t              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [7:0]            w_len_q, w_len_d;
    logic [2:0]            w_size_q, w_size_d;
    logic [1:0]            w_burst_q, w_burst_d;
    logic [7:0]            w_cnt_q, w_cnt_d;
    logic [3:0]            bid_q, bid_d;
    logic                  w_decerr_q, w_decerr_d;
    logic                  w_slverr_q, w_slverr_d;
    logic                  aw_hs, w_hs, w_final;

    assign bus.awready = (w_state_q == W_IDLE) & ~rst;
    assign bus.wready  = (w_state_q == W_DATA);
    assign bus.bvalid  = (w_state_q == W_RESP);
    assign bus.bid     = bid_q;
    assign bus.bresp   = w_decerr_q ? 2'b11 : (w_slverr_q ? 2'b10 : 2'b00);
    assign aw_hs       = bus.awvalid & bus.awready;
    assign w_hs        = bus.wvalid & bus.wready;
    assign w_final     = (w_cnt_q == w_len_q);

    // Write next-state; errors are sticky across the burst and cleared when B is taken.
    always_comb begin
        w_state_d  = w_state_q;
        w_addr_d   = w_addr_q;
        w_len_d    = w_len_q;
        w_size_d   = w_size_q;
        w_burst_d  = w_burst_q;
        w_cnt_d    = w_cnt_q;
        bid_d      = bid_q;
        w_decerr_d = w_decerr_q;
        w_slverr_d = w_slverr_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_addr_d  = bus.awaddr;
                    w_len_d   = bus.awlen;
                    w_size_d  = bus.awsize;
                    w_burst_d = bus.awburst;
                    bid_d     = bus.awid;
                    w_cnt_d   = 8'd0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    if (!in_range(w_addr_q)) w_decerr_d = 1'b1;
                    if (bus.wlast != w_final) w_slverr_d = 1'b1;
                    if (w_final) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
                        w_cnt_d  = w_cnt_q + 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    w_state_d  = W_IDLE;
                    w_decerr_d = 1'b0;
                    w_slverr_d = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write state register
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q  <= W_IDLE;
            w_addr_q   <= '0;
            w_len_q    <= '0;
            w_size_q   <= '0;
            w_burst_q  <= '0;
            w_cnt_q    <= '0;
            bid_q      <= '0;
            w_decerr_q <= 1'b0;
            w_slverr_q <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            w_addr_q   <= w_addr_d;
            w_len_q    <= w_len_d;
            w_size_q   <= w_size_d;
            w_burst_q  <= w_burst_d;
            w_cnt_q    <= w_cnt_d;
            bid_q      <= bid_d;
            w_decerr_q <= w_decerr_d;
            w_slverr_q <= w_slverr_d;
        end
    end

    // Byte-lane memory update; contents survive reset and out-of-range beats are dropped.
    always_ff @(posedge clk) begin
        if (w_hs && in_range(w_addr_q)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (bus.wstrb[b]) mem[word_idx(w_addr_q)][b*8 +: 8] <= bus.wdata[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_offnariscv_ace_mem_responder.sv
// tb/tb_offnariscv_ace_mem_responder.sv - scoreboard bench for the ACE memory responder
module tb_offnariscv_ace_mem_responder;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam longint      MEMB = 65536;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    offnariscv_ace_mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    offnariscv_ace_mem_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_BYTES(65536), .BASE_ADDR(32'h8000_0000)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {logic [3:0] id; logic [31:0] data; logic [3:0] resp; logic last;} r_exp_t;
    typedef struct {logic [3:0] id; logic [1:0] resp;} b_exp_t;

    r_exp_t     r_q[$];
    b_exp_t     b_q[$];
    bit [7:0]   mem_m [bit [31:0]];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + MEMB);
    endfunction

    // Address of beat i from the burst definition: FIXED repeats, INCR steps, WRAP stays in its block.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int burst, input int i);
        int unsigned s, n, blk;
        logic [31:0] lower;
        s = 4;
        n = len + 1;
        if (burst == 0) return a;
        if (burst == 2 && (n == 2 || n == 4 || n == 8 || n == 16)) begin
            blk   = n * s;
            lower = a - (a % blk);
            return lower + ((a - lower) + i * s) % blk;
        end
        return a + i * s;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [31:0] al;
        al = a & ~32'h3;
        return {mem_m[al+3], mem_m[al+2], mem_m[al+1], mem_m[al]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every R/B handshake against the scoreboard and checks hold under backpressure.
    logic        r_hold, b_hold;
    logic [31:0] h_data;
    logic [3:0]  h_id, h_resp;
    logic        h_last;
    logic [3:0]  hb_id;
    logic [1:0]  hb_resp;
    always @(negedge clk) begin
        r_exp_t e;
        b_exp_t be;
        if (rst) begin
            r_hold = 1'b0;
            b_hold = 1'b0;
        end else begin
            if (r_hold) begin
                check("r_hold_valid", bus.rvalid, 1'b1);
                check("r_hold_payload", {bus.rdata, bus.rid, bus.rresp, bus.rlast}, {h_data, h_id, h_resp, h_last});
            end
            if (bus.rvalid && bus.rready) begin
                if (r_q.size() == 0) begin
                    check("r_unexpected_beat", r_q.size(), 1);
                end else begin
                    e = r_q.pop_front();
                    check("r_data", bus.rdata, e.data);
                    check("r_resp", bus.rresp, e.resp);
                    check("r_last", bus.rlast, e.last);
                    check("r_id", bus.rid, e.id);
                end
            end
            r_hold = bus.rvalid && !bus.rready;
            h_data = bus.rdata; h_id = bus.rid; h_resp = bus.rresp; h_last = bus.rlast;
            if (b_hold) begin
                check("b_hold_valid", bus.bvalid, 1'b1);
                check("b_hold_payload", {bus.bid, bus.bresp}, {hb_id, hb_resp});
            end
            if (bus.bvalid && bus.bready) begin
                if (b_q.size() == 0) begin
                    check("b_unexpected", b_q.size(), 1);
                end else begin
                    be = b_q.pop_front();
                    check("b_resp", bus.bresp, be.resp);
                    check("b_id", bus.bid, be.id);
                end
            end
            b_hold = bus.bvalid && !bus.bready;
            hb_id = bus.bid; hb_resp = bus.bresp;
        end
    end

    task automatic ar_send(input logic [31:0] addr, input int len, input int burst, input logic [3:0] id);
        logic ok;
        int n;
        bus.araddr = addr; bus.arlen = 8'(len); bus.arsize = 3'd2; bus.arburst = 2'(burst);
        bus.arid = id; bus.arsnoop = 4'($urandom); bus.ardomain = 2'($urandom); bus.arvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = bus.arready;
            tick();
            n++;
        end while (!ok && n < 100);
        check("ar_handshake", ok, 1'b1);
        bus.arvalid = 1'b0;
    endtask

    task automatic aw_send(input logic [31:0] addr, input int len, input int burst, input logic [3:0] id);
        logic ok;
        int n;
        bus.awaddr = addr; bus.awlen = 8'(len); bus.awsize = 3'd2; bus.awburst = 2'(burst);
        bus.awid = id; bus.awsnoop = 3'($urandom); bus.awdomain = 2'($urandom); bus.awvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = bus.awready;
            tick();
            n++;
        end while (!ok && n < 100);
        check("aw_handshake", ok, 1'b1);
        bus.awvalid = 1'b0;
    endtask

    // bp: 0 = rready held high, 1 = toggling, 2 = random
    task automatic do_read(input logic [31:0] addr, input int len, input int burst, input logic [3:0] id, input int bp);
        r_exp_t e;
        logic [31:0] ba;
        logic done;
        int n;
        for (int i = 0; i <= len; i++) begin
            ba = beat_addr(addr, len, burst, i);
            e.id = id;
            e.last = (i == len);
            if (in_rng(ba)) begin
                e.data = model_word(ba); e.resp = 4'b0000;
            end else begin
                e.data = 32'h0; e.resp = 4'b0011;
            end
            r_q.push_back(e);
        end
        bus.rready = (bp == 0);
        ar_send(addr, len, burst, id);
        @(negedge clk);
        check("ar_to_rvalid", bus.rvalid, 1'b1);
        done = 1'b0;
        n = 0;
        while (!done && n < 400) begin
            done = bus.rvalid && bus.rready && bus.rlast;
            tick();
            n++;
            if (bp == 1) bus.rready = ~bus.rready;
            else if (bp == 2) bus.rready = 1'($urandom);
            if (!done) @(negedge clk);
        end
        check("r_burst_done", done, 1'b1);
        bus.rready = 1'b0;
    endtask

    // Uses wd/ws as beat data; err_beat >= 0 flips wlast on that beat.
    task automatic do_write(input logic [31:0] addr, input int len, input int burst, input logic [3:0] id, input int err_beat);
        b_exp_t be;
        logic [31:0] ba;
        logic dec, slv, ok;
        int n;
        dec = 0;
        slv = (err_beat >= 0 && err_beat <= len);
        for (int i = 0; i <= len; i++) begin
            ba = beat_addr(addr, len, burst, i);
            if (in_rng(ba)) begin
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) mem_m[(ba & ~32'h3) + b] = wd[i][b*8 +: 8];
            end else begin
                dec = 1;
            end
        end
        be.id = id;
        be.resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
        b_q.push_back(be);
        aw_send(addr, len, burst, id);
        @(negedge clk);
        check("aw_to_wready", bus.wready, 1'b1);
        tick();
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            bus.wdata = wd[i]; bus.wstrb = ws[i];
            bus.wlast = (i == len) != (i == err_beat);
            bus.wvalid = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                ok = bus.wready && bus.wvalid;
                tick();
                n++;
            end while (!ok && n < 100);
            check("w_handshake", ok, 1'b1);
            bus.wvalid = 1'b0;
        end
        @(negedge clk);
        check("w_to_bvalid", bus.bvalid, 1'b1);
        tick();
        repeat ($urandom_range(0, 2)) tick();
        bus.bready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = bus.bvalid && bus.bready;
            tick();
            n++;
        end while (!ok && n < 100);
        check("b_handshake", ok, 1'b1);
        bus.bready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int len, burst, w, err;
        logic [31:0] addr;
        bus.arvalid = 0; bus.awvalid = 0; bus.wvalid = 0; bus.rready = 0; bus.bready = 0;
        bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0; bus.arid = 0;
        bus.arsnoop = 0; bus.ardomain = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0;
        bus.awburst = 0; bus.awid = 0; bus.awsnoop = 0; bus.awdomain = 0;
        bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.rack = 0; bus.wack = 0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_arready", bus.arready, 1'b0);
        check("rst_awready", bus.awready, 1'b0);
        check("rst_valids", {bus.rvalid, bus.rlast, bus.bvalid, bus.wready}, 4'b0);
        check("rst_payload", {bus.rdata, bus.rid, bus.rresp, bus.bid, bus.bresp}, 46'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("idle_arready", bus.arready, 1'b1);
        check("idle_awready", bus.awready, 1'b1);
        tick();

        // Fill the first 64 words so later random reads see defined data
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            do_write(BASE + 32'(blk * 64), 15, 1, 4'(blk), -1);
        end

        // Single read
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        do_write(32'h8000_0010, 0, 1, 4'h1, -1);
        do_read(32'h8000_0010, 0, 1, 4'h2, 0);

        // INCR write then read
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(32'h8000_0000, 3, 1, 4'h3, -1);
        do_read(32'h8000_0000, 3, 1, 4'h4, 0);

        // WRAP: A,B,C,D read from the third word
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA + 32'(i); ws[i] = 4'hF; end
        do_write(32'h8000_0000, 3, 1, 4'h5, -1);
        do_read(32'h8000_0008, 3, 2, 4'h6, 0);

        // Byte strobe merge
        wd[0] = 32'h1122_3344; ws[0] = 4'hF;
        do_write(32'h8000_0020, 0, 1, 4'h7, -1);
        wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
        do_write(32'h8000_0020, 0, 1, 4'h8, -1);
        do_read(32'h8000_0020, 0, 1, 4'h9, 0);

        // Out of range, fully and straddling both ends of the window
        do_read(32'h0000_0000, 1, 1, 4'hA, 0);
        wd[0] = 32'h5555_5555; wd[1] = 32'h6666_6666; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(32'h0000_0000, 1, 1, 4'hB, -1);
        do_read(BASE - 32'd4, 1, 1, 4'hC, 0);
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(BASE + 32'(MEMB) - 32'd8, 3, 1, 4'hD, -1);
        do_read(BASE + 32'(MEMB) - 32'd8, 3, 1, 4'hE, 0);

        // Backpressure and wlast error
        do_read(32'h8000_0040, 7, 1, 4'hF, 1);
        wd[0] = 32'h0BAD_0000; wd[1] = 32'h0BAD_0001; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(32'h8000_0080, 1, 1, 4'h3, 0);
        do_read(32'h8000_0080, 1, 1, 4'h4, 0);

        // Randomized traffic within the filled window
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
                0: len = 0;
                1: len = 1;
                2: len = 2;
                3: len = 3;
                4: len = 5;
                default: len = 7;
            endcase
            burst = $urandom_range(0, 3);
            w = $urandom_range(0, 63 - len);
            addr = BASE + 32'(w * 4);
            if ($urandom_range(0, 7) == 0) addr = 32'h1000_0000 + 32'(w * 4);
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
                err = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
                do_write(addr, len, burst, 4'($urandom), err);
            end else begin
                do_read(addr, len, burst, 4'($urandom), $urandom_range(0, 2));
            end
        end

        // Reset in the middle of a stalled read abandons it
        bus.rready = 1'b0;
        ar_send(32'h8000_0000, 3, 1, 4'h1);
        tick();
        rst = 1'b1;
        tick();
        r_q.delete();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_rvalid", bus.rvalid, 1'b0);
        check("mid_rst_arready", bus.arready, 1'b1);
        tick();
        do_read(32'h8000_0000, 3, 1, 4'h2, 0);

        repeat (3) tick();
        check("r_queue_empty", r_q.size(), 0);
        check("b_queue_empty", b_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/offnariscv_ace_mem_responder.md
# offnariscv_ace_mem_responder

Memory-side responder for the core's ACE read and write channels. It accepts AR/AW requests from the offnariscv cache/fetch initiators, returns R beats and B responses from an internal byte-addressed memory, and replies as a non-snooping, non-sharing slave. It is the endpoint used in core-level simulation and on FPGA builds without an external interconnect.

## Interface
- DATA_WIDTH, XLEN (32), data bus width; must be 32 or 64
- ADDR_WIDTH, XLEN (32), address width
- MEM_BYTES, 65536, memory size; power of two
- BASE_ADDR, 32'h8000_0000, first mapped byte; aligned to MEM_BYTES

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- arid / araddr / arlen / arsize / arburst  in  ACE_XID_WIDTH / ADDR_WIDTH / ACE_AXLEN_WIDTH / ACE_AXSIZE_WIDTH / ACE_AXBURST_WIDTH  read request
- arsnoop / ardomain  in  ACE_ARSNOOP_WIDTH / ACE_DOMAIN_WIDTH  accepted, ignored
- arvalid in 1; arready out 1
- rid out ACE_XID_WIDTH; rdata out DATA_WIDTH; rresp out ACE_RRESP_WIDTH; rlast out 1; rvalid out 1; rready in 1
- awid / awaddr / awlen / awsize / awburst  in  same widths as AR
- awsnoop / awdomain  in  ACE_AWSNOOP_WIDTH / ACE_DOMAIN_WIDTH  ignored
- awvalid in 1; awready out 1
- wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8; wlast in 1; wvalid in 1; wready out 1
- bid out ACE_XID_WIDTH; bresp out ACE_BRESP_WIDTH; bvalid out 1; bready in 1
- rack / wack  in  1  ignored

## Operation
- Read FSM R_IDLE -> R_BURST -> R_IDLE; write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE. The two are independent, one outstanding transaction each.
- arready = (R_IDLE) & ~rst; awready = (W_IDLE) & ~rst; wready = (W_DATA).
- AR handshake: capture id, addr, len, size, burst; beat counter = 0; go R_BURST.
- R_BURST: present beat; on rvalid&rready advance address and counter; rlast = (counter == len); handshake with rlast returns to R_IDLE.
- Address step s = 1<<size. FIXED: unchanged. INCR: addr+s. WRAP: addr+s within boundary (len+1)*s aligned; for len not in {1,3,7,15} WRAP behaves as INCR. Reserved burst (2'b11) treated as INCR.
- rdata = memory word at addr aligned down to DATA_WIDTH/8; rresp[1:0] OKAY, rresp[3:2] (PassDirty, IsShared) always 0. Beat address outside [BASE_ADDR, BASE_ADDR+MEM_BYTES): rdata 0, rresp[1:0] DECERR, rest of burst continues.
- AW handshake: capture fields; go W_DATA. Each W handshake writes bytes with wstrb=1 at aligned beat address (out-of-range beats discarded, set sticky DECERR). Burst ends on handshake where counter == awlen; go W_RESP. wlast disagreeing with counter on any beat sets sticky SLVERR (DECERR wins).
- W_RESP: bvalid=1, bid = captured id, bresp = sticky result; bready -> W_IDLE, stickies cleared.
- Same-cycle read load and write to same word: read returns pre-write data.

## Timing
- Reset: rvalid, rlast, bvalid, wready = 0; rdata, rid, rresp, bid, bresp = 0; both FSMs idle; arready/awready 0 during rst. Memory contents not reset.
- AR handshake cycle N -> first rvalid at N+1. Following beats one cycle after each R handshake (full throughput with rready held high). rvalid and R payload stable until handshake.
- AW handshake N -> wready at N+1. Final W handshake M -> bvalid at M+1. Next AR/AW accepted the cycle after rlast/B handshake.
- rst mid-burst abandons both transactions next cycle; memory writes already performed persist.

## Test plan
- Single read: memory preloaded 0xDEADBEEF at 0x8000_0010; AR addr 0x8000_0010 len 0 size 2 INCR -> rvalid next cycle, rdata 0xDEADBEEF, rresp 0, rlast 1.
- INCR write then read: AW 0x8000_0000 len 3, W data 1,2,3,4 wstrb 0xF, wlast on 4th -> bresp OKAY; read back len 3 -> 1,2,3,4, rlast on 4th only.
- WRAP: words 0x8000_0000..0C hold A,B,C,D; AR 0x8000_0008 len 3 WRAP size 2 -> C,D,A,B.
- Byte strobe: word 0x11223344, write 0xAABBCCDD wstrb 4'b0101 -> read 0x11BB33DD.
- Out of range: AR 0x0000_0000 len 1 -> two beats rdata 0, rresp[1:0] 2'b11; AW to same -> bresp DECERR, memory unchanged.
- Backpressure and wlast error: rready toggled every other cycle on len 7 read -> 8 beats, payload held; write len 1 with wlast on beat 0 -> bresp SLVERR.
